instruction_loader: RTL and testbench

- Write-side counterpart of the instruction fetch/decode path.
- Accepts decoded instruction fields (opcode, funct3, funct7, rs1, rs2, rd, 12-bit immediate) over a valid/ready handshake.
- Re-encodes them into 32-bit RV32 words and writes them to consecutive instruction-memory locations from a programmable base address.
- Sits between the program source (testbench or boot sequencer) and the instruction memory write port.

---
 rtl/instruction_loader_pkg.sv | 32 +++
 rtl/instruction_loader_encoder.sv | 49 ++++
 rtl/instruction_loader.sv | 148 ++++++++++++++
 tb/tb_instruction_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the fetch/decode path:
// supported RV32 opcodes, the loader state encoding and field bit positions.
// Optional feature macro: LOADER_READBACK_EN (adds the VERIFY state).
package instruction_loader_pkg;

    // Opcodes the loader knows how to re-encode
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Field bit positions inside a 32-bit RV32 instruction word
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int IMM_I_LSB  = 20;

    // Loader FSM states; VERIFY only exists when readback is built in
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef LOADER_READBACK_EN
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2
`else
        ST_WRITE  = 2'd1
`endif
    } loader_state_e;

endpackage

// File: rtl/instruction_loader_encoder.sv
// Combinational fields-to-word encoder for the instruction loader.
// Produces the RV32 word for R, load, store and branch formats and flags
// whether the opcode is one of those.
module instr_encoder
    import instruction_loader_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [11:0] immediate_i,
    output logic [31:0] word_o,
    output logic        supported_o
);

    // Place each field at its format-specific position; branch shares the S split
    always_comb begin
        word_o      = '0;
        supported_o = 1'b0;
        word_o[OPCODE_LSB +: 7] = opcode_i;
        word_o[FUNCT3_LSB +: 3] = funct3_i;
        word_o[RS1_LSB    +: 5] = rs1_i;
        case (opcode_i)
            OP_R: begin
                supported_o             = 1'b1;
                word_o[RD_LSB     +: 5] = rd_i;
                word_o[RS2_LSB    +: 5] = rs2_i;
                word_o[FUNCT7_LSB +: 7] = funct7_i;
            end
            OP_LOAD: begin
                supported_o             = 1'b1;
                word_o[RD_LSB    +: 5]  = rd_i;
                word_o[IMM_I_LSB +: 12] = immediate_i;
            end
            OP_STORE, OP_BRANCH: begin
                supported_o             = 1'b1;
                word_o[RD_LSB     +: 5] = immediate_i[4:0];
                word_o[RS2_LSB    +: 5] = rs2_i;
                word_o[FUNCT7_LSB +: 7] = immediate_i[11:5];
            end
            default: begin
                supported_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: accepts decoded instruction fields over valid/ready,
// re-encodes them and writes them to consecutive instruction-memory words
// starting at a programmable base address (wrapping modulo DEPTH).
// Optional feature macro: LOADER_READBACK_EN adds a readback VERIFY cycle,
// the mem_rdata input and the sticky verify_err output.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [11:0]       immediate,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef LOADER_READBACK_EN
    input  logic [31:0]       mem_rdata,
    output logic              verify_err,
`endif
    output logic [ADDR_W:0]   words_written,
    output logic              full,
    output logic              err_opcode,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [31:0]       word_q;
    logic              we_q;
    logic              err_opcode_q;
    logic [31:0]       enc_word;
    logic              enc_supported;
    logic              accept;
`ifdef LOADER_READBACK_EN
    logic              verify_err_q;
`endif

    instr_encoder u_encoder (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rd_i        (rd),
        .immediate_i (immediate),
        .word_o      (enc_word),
        .supported_o (enc_supported)
    );

    assign full     = (count_q == DEPTH_CNT);
    assign in_ready = (state_q == ST_IDLE) && !full && !start;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = word_q;
    assign words_written = count_q;
    assign err_opcode    = err_opcode_q;
`ifdef LOADER_READBACK_EN
    assign verify_err    = verify_err_q;
`endif

    // Post-write address (wrapping at DEPTH, not at 2**ADDR_W) and count
    always_comb begin
        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
    end

    // Loader FSM: handshake, write strobe, optional readback, counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            word_q       <= '0;
            we_q         <= 1'b0;
            err_opcode_q <= 1'b0;
`ifdef LOADER_READBACK_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q       <= base_addr;
                        count_q      <= '0;
                        err_opcode_q <= 1'b0;
`ifdef LOADER_READBACK_EN
                        verify_err_q <= 1'b0;
`endif
                    end else if (accept) begin
                        if (enc_supported) begin
                            word_q  <= enc_word;
                            we_q    <= 1'b1;
                            state_q <= ST_WRITE;
                        end else begin
                            err_opcode_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    we_q <= 1'b0;
`ifdef LOADER_READBACK_EN
                    state_q <= ST_VERIFY;
`else
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    state_q <= ST_IDLE;
`endif
                end
`ifdef LOADER_READBACK_EN
                ST_VERIFY: begin
                    if (mem_rdata != word_q) begin
                        verify_err_q <= 1'b1;
                    end
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    state_q <= ST_IDLE;
                end
`endif
                default: begin
                    we_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed, table-driven bench for instruction_loader (DEPTH=4 instance),
// plus hand-written sequences for full/wrap, start races and reset abort.
// Optional feature macro: LOADER_READBACK_EN (adds readback checks).
module tb_instruction_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
`ifdef LOADER_READBACK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clock;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [11:0]       immediate;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              full;
    logic              err_opcode;
    logic              busy;
`ifdef LOADER_READBACK_EN
    logic [31:0]       mem_rdata;
    logic              verify_err;
    logic [31:0]       benchMem [DEPTH];
    logic [31:0]       corruptMask;
`endif

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [1:0]  base;
        logic        expWe;
        logic [31:0] expWord;
    } vec_t;

    vec_t vecs [9];

    instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clock),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .immediate     (immediate),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
`ifdef LOADER_READBACK_EN
        .mem_rdata     (mem_rdata),
        .verify_err    (verify_err),
`endif
        .words_written (words_written),
        .full          (full),
        .err_opcode    (err_opcode),
        .busy          (busy)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

`ifdef LOADER_READBACK_EN
    // Behavioural instruction memory with an optional read corruption mask
    always @(posedge clock) begin
        if (mem_we) begin
            benchMem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = benchMem[mem_addr] ^ corruptMask;
`endif

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse start with a base address and check the loader re-armed
    task automatic startLoader(input logic [ADDR_W-1:0] b);
        @(negedge clock);
        start     = 1'b1;
        base_addr = b;
        #1 checkOutput("ready_low_during_start", 32'(in_ready), 32'd0);
        @(negedge clock);
        start = 1'b0;
        #1;
        checkOutput("start_addr", 32'(mem_addr), 32'(b));
        checkOutput("start_count", 32'(words_written), 32'd0);
    endtask

    // Present one field bundle and hold it until accepted; returns in cycle N+1
    task automatic applyStimulus(input vec_t v);
        int waitCycles;
        @(negedge clock);
        opcode    = v.opcode;
        funct3    = v.funct3;
        funct7    = v.funct7;
        rs1       = v.rs1;
        rs2       = v.rs2;
        rd        = v.rd;
        immediate = v.imm;
        in_valid  = 1'b1;
        waitCycles = 0;
        #1;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clock);
            #1;
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1;
    endtask

    function automatic vec_t mkVec(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                   logic [4:0] s1, logic [4:0] s2, logic [4:0] d, logic [11:0] im,
                                   logic [1:0] b, logic we, logic [31:0] w);
        vec_t v;
        v.name = n; v.opcode = op; v.funct3 = f3; v.funct7 = f7;
        v.rs1 = s1; v.rs2 = s2; v.rd = d; v.imm = im;
        v.base = b; v.expWe = we; v.expWord = w;
        return v;
    endfunction

    // Main directed test sequence
    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0; immediate = '0;
`ifdef LOADER_READBACK_EN
        corruptMask = '0;
        for (int i = 0; i < DEPTH; i++) benchMem[i] = '0;
`endif

        vecs[0] = mkVec("lw",        7'b0000011, 3'b010, 7'h00,  5'd0,  5'd0,  5'd1,  12'd0,   2'd0, 1'b1, 32'h00002083);
        vecs[1] = mkVec("mul",       7'b0110011, 3'b000, 7'h01,  5'd2,  5'd1,  5'd1,  12'd0,   2'd3, 1'b1, 32'h021100B3);
        vecs[2] = mkVec("sw",        7'b0100011, 3'b010, 7'h00,  5'd2,  5'd1,  5'd0,  12'd2,   2'd1, 1'b1, 32'h00112123);
        vecs[3] = mkVec("branch",    7'b1100011, 3'b000, 7'h00,  5'd2,  5'd3,  5'd0,  12'd3,   2'd2, 1'b1, 32'h003101E3);
        vecs[4] = mkVec("lw_ignore", 7'b0000011, 3'b111, 7'h7F,  5'd31, 5'd31, 5'd31, 12'hABC, 2'd0, 1'b1, 32'hABCFFF83);
        vecs[5] = mkVec("sw_ignore", 7'b0100011, 3'b000, 7'h55,  5'd0,  5'd0,  5'd5,  12'hFFF, 2'd1, 1'b1, 32'hFE000FA3);
        vecs[6] = mkVec("r_ones",    7'b0110011, 3'b111, 7'h7F,  5'd31, 5'd31, 5'd31, 12'd0,   2'd2, 1'b1, 32'hFFFFFFB3);
        vecs[7] = mkVec("bad_7f",    7'b1111111, 3'b000, 7'h00,  5'd1,  5'd1,  5'd1,  12'd0,   2'd3, 1'b0, 32'h0);
        vecs[8] = mkVec("bad_opimm", 7'b0010011, 3'b000, 7'h00,  5'd1,  5'd1,  5'd1,  12'd1,   2'd1, 1'b0, 32'h0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_words", 32'(words_written), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_err_opcode", 32'(err_opcode), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOADER_READBACK_EN
        checkOutput("rst_verify_err", 32'(verify_err), 32'd0);
`endif

        // Table-driven encodings, each from a fresh start
        for (int i = 0; i < 9; i++) begin
            startLoader(vecs[i].base);
            applyStimulus(vecs[i]);
            if (vecs[i].expWe) begin
                checkOutput({vecs[i].name, "_we"}, 32'(mem_we), 32'd1);
                checkOutput({vecs[i].name, "_addr"}, 32'(mem_addr), 32'(vecs[i].base));
                checkOutput({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].expWord);
                checkOutput({vecs[i].name, "_ready_low"}, 32'(in_ready), 32'd0);
                checkOutput({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
            end else begin
                checkOutput({vecs[i].name, "_no_we"}, 32'(mem_we), 32'd0);
                checkOutput({vecs[i].name, "_err"}, 32'(err_opcode), 32'd1);
                checkOutput({vecs[i].name, "_addr_kept"}, 32'(mem_addr), 32'(vecs[i].base));
                checkOutput({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
            end
            repeat (LAT - 1) @(negedge clock);
            #1;
            checkOutput({vecs[i].name, "_we_done"}, 32'(mem_we), 32'd0);
            checkOutput({vecs[i].name, "_words"}, 32'(words_written), vecs[i].expWe ? 32'd1 : 32'd0);
            checkOutput({vecs[i].name, "_ready_back"}, 32'(in_ready), 32'd1);
        end

        // err_opcode is still set from the last vector; start clears it
        startLoader(2'd0);
        checkOutput("err_cleared_by_start", 32'(err_opcode), 32'd0);

        // Full and wrap: four writes from base 2 land at 2,3,0,1
        startLoader(2'd2);
        for (int k = 0; k < 4; k++) begin
            v = vecs[0];
            v.rd = 5'(k);
            applyStimulus(v);
            checkOutput("wrap_we", 32'(mem_we), 32'd1);
            checkOutput("wrap_addr", 32'(mem_addr), 32'((2 + k) % DEPTH));
            repeat (LAT - 1) @(negedge clock);
            #1;
        end
        checkOutput("full_set", 32'(full), 32'd1);
        checkOutput("full_ready_low", 32'(in_ready), 32'd0);
        checkOutput("full_words", 32'(words_written), 32'd4);
        @(negedge clock);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1 checkOutput("full_stall_no_we", 32'(mem_we), 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("full_words_held", 32'(words_written), 32'd4);
        startLoader(2'd0);
        checkOutput("full_cleared", 32'(full), 32'd0);

        // start while busy is ignored
        startLoader(2'd0);
        applyStimulus(vecs[1]);
        start     = 1'b1;
        base_addr = 2'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (LAT - 2) @(negedge clock);
        #1;
        checkOutput("busy_start_addr", 32'(mem_addr), 32'd1);
        checkOutput("busy_start_words", 32'(words_written), 32'd1);

        // start and in_valid together: start wins, no transfer
        @(negedge clock);
        start     = 1'b1;
        base_addr = 2'd1;
        in_valid  = 1'b1;
        opcode    = 7'b0000011;
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("race_no_we", 32'(mem_we), 32'd0);
        checkOutput("race_addr", 32'(mem_addr), 32'd1);
        checkOutput("race_words", 32'(words_written), 32'd0);
        checkOutput("race_idle", 32'(busy), 32'd0);

`ifdef LOADER_READBACK_EN
        // Readback: clean compare, then corrupted compare still advances
        startLoader(2'd0);
        applyStimulus(vecs[2]);
        repeat (LAT - 1) @(negedge clock);
        #1 checkOutput("verify_clean", 32'(verify_err), 32'd0);
        corruptMask = 32'h0000_0100;
        applyStimulus(vecs[3]);
        repeat (LAT - 1) @(negedge clock);
        #1;
        corruptMask = '0;
        checkOutput("verify_err_set", 32'(verify_err), 32'd1);
        checkOutput("verify_words", 32'(words_written), 32'd2);
        checkOutput("verify_addr", 32'(mem_addr), 32'd2);
        startLoader(2'd0);
        checkOutput("verify_err_cleared", 32'(verify_err), 32'd0);
`endif

        // Reset during WRITE aborts the pending operation
        startLoader(2'd2);
        applyStimulus(vecs[0]);
        checkOutput("abort_we_before", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        #1;
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        checkOutput("abort_words", 32'(words_written), 32'd0);
        checkOutput("abort_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
